// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared sizing helpers for the pipelined ripple adder
package adder_pkg;

  function automatic int calc_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Lowest bit of slice k; slice k is [slice_lo(k) +: chunk]
  function automatic int slice_lo(input int k, input int chunk);
    return k * chunk;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// rtl/adder_chunk.sv - combinational CHUNK-bit ripple adder built from full-adder cells
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[CHUNK];
  // Carry into the top bit; XOR with cout gives signed overflow on the last slice
  assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// rtl/pipelined_ripple_adder.sv - add/subtract unit, one CHUNK-bit slice resolved per pipeline stage
module pipelined_ripple_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);

  if ((WIDTH % CHUNK) != 0 || STAGES < 1) begin : g_bad_params
    $error("pipelined_ripple_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic             advance;
  logic [WIDTH-1:0] eff_b;
  logic             eff_cin;

  // Per-stage state: operands travel with the beat, s_q holds the slices resolved so far
  logic             v_q [STAGES];
  logic             c_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             ovf_q;

  logic [CHUNK-1:0] chunk_s    [STAGES];
  logic             chunk_cout [STAGES];
  logic             chunk_cmsb [STAGES];
  logic [WIDTH-1:0] s_nxt      [STAGES];

  assign eff_b   = sub ? ~b : b;
  assign eff_cin = sub ? ~c_in : c_in;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign c_out     = c_q[STAGES-1];
  assign overflow  = ovf_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = slice_lo(k, CHUNK);
    logic [CHUNK-1:0] x;
    logic [CHUNK-1:0] y;
    logic             ci;
    logic [WIDTH-1:0] base;

    if (k == 0) begin : g_first
      assign x    = a[LO +: CHUNK];
      assign y    = eff_b[LO +: CHUNK];
      assign ci   = eff_cin;
      assign base = '0;
    end else begin : g_next
      assign x    = a_q[k-1][LO +: CHUNK];
      assign y    = b_q[k-1][LO +: CHUNK];
      assign ci   = c_q[k-1];
      assign base = s_q[k-1];
    end

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .x    (x),
      .y    (y),
      .cin  (ci),
      .s    (chunk_s[k]),
      .cout (chunk_cout[k]),
      .cmsb (chunk_cmsb[k])
    );

    // Unresolved slices of base are always zero, so OR merges the new slice in place
    assign s_nxt[k] = base | (WIDTH'(chunk_s[k]) << LO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      v_q[0] <= in_valid;
      a_q[0] <= a;
      b_q[0] <= eff_b;
      for (int k = 1; k < STAGES; k++) begin
        v_q[k] <= v_q[k-1];
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        s_q[k] <= s_nxt[k];
        c_q[k] <= chunk_cout[k];
      end
      ovf_q <= chunk_cmsb[STAGES-1] ^ chunk_cout[STAGES-1];
    end
  end

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// tb/tb_pipelined_ripple_adder.sv - randomized and directed bench for pipelined_ripple_adder
module tb_pipelined_ripple_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit / 4-bit-chunk instance (2 stages)
  logic       rst8 = 1'b1, iv8 = 1'b0, ci8 = 1'b0, sb8 = 1'b0, or8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ir8, ov8, co8, of8;
  logic [7:0] sum8;

  // 3-bit / 1-bit-chunk instance (3 stages)
  logic       rst3 = 1'b1, iv3 = 1'b0, ci3 = 1'b0, sb3 = 1'b0, or3 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0;
  logic       ir3, ov3, co3, of3;
  logic [2:0] sum3;

  pipelined_ripple_adder #(.WIDTH(8), .CHUNK(4)) u_dut8 (
    .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .c_in(ci8), .sub(sb8), .out_valid(ov8), .out_ready(or8), .sum(sum8),
    .c_out(co8), .overflow(of8)
  );

  pipelined_ripple_adder #(.WIDTH(3), .CHUNK(1)) u_dut3 (
    .clk(clk), .rst(rst3), .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3),
    .c_in(ci3), .sub(sb3), .out_valid(ov3), .out_ready(or3), .sum(sum3),
    .c_out(co3), .overflow(of3)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    int         t;
    logic [9:0] v;
  } exp_t;
  exp_t q[$];

  // Returns {overflow, c_out, sum[7:0]} from plain integer arithmetic
  function automatic logic [9:0] ref_model(input int w, input int x, input int y,
                                           input int ci, input int s);
    int m, full, sx, sy, sr;
    logic ov, co;
    logic [7:0] sm;
    m = 1 << w;
    if (s == 0) full = x + y + ci;
    else        full = x + (m - 1 - y) + (1 - ci);
    sx = (x >= m / 2) ? x - m : x;
    sy = (y >= m / 2) ? y - m : y;
    sr = (s != 0) ? sx - sy - ci : sx + sy + ci;
    ov = (sr >= m / 2) || (sr < -(m / 2));
    co = (full >= m);
    sm = 8'(full % m);
    return {ov, co, sm};
  endfunction

  task automatic tick8(input logic r, input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                       input logic ic, input logic is, input logic ordy);
    @(negedge clk);
    rst8 = r; iv8 = iv; a8 = ia; b8 = ib; ci8 = ic; sb8 = is; or8 = ordy;
    #1;
  endtask

  task automatic tick3(input logic r, input logic iv, input logic [2:0] ia, input logic [2:0] ib,
                       input logic ic, input logic is, input logic ordy);
    @(negedge clk);
    rst3 = r; iv3 = iv; a3 = ia; b3 = ib; ci3 = ic; sb3 = is; or3 = ordy;
    #1;
  endtask

  task automatic test_reset();
    int stray;
    tick8(1'b1, 1'b1, 8'h55, 8'h22, 1'b0, 1'b0, 1'b1);
    tick8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    total_cnt++; if (ov8 !== 1'b0) $display("FAIL reset_out_valid got %b want 0", ov8); else pass_cnt++;
    total_cnt++; if (sum8 !== 8'h00) $display("FAIL reset_sum got %h want 00", sum8); else pass_cnt++;
    total_cnt++; if (co8 !== 1'b0) $display("FAIL reset_c_out got %b want 0", co8); else pass_cnt++;
    total_cnt++; if (of8 !== 1'b0) $display("FAIL reset_overflow got %b want 0", of8); else pass_cnt++;
    total_cnt++; if (ir8 !== 1'b1) $display("FAIL reset_in_ready got %b want 1", ir8); else pass_cnt++;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      tick8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      if (ov8 === 1'b1) stray++;
    end
    total_cnt++; if (stray !== 0) $display("FAIL reset_beat_dropped got %0d outputs want 0", stray); else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [7:0] ta[5] = '{8'h7F, 8'hFF, 8'h05, 8'h80, 8'h10};
    logic [7:0] tb[5] = '{8'h01, 8'h01, 8'h07, 8'h01, 8'h0F};
    logic       tc[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       ts[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] es[5] = '{8'h80, 8'h00, 8'hFE, 8'h7F, 8'h20};
    logic       ec[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       eo[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int n;
    for (int v = 0; v < 5; v++) begin
      tick8(1'b0, 1'b1, ta[v], tb[v], tc[v], ts[v], 1'b1);
      total_cnt++; if (ir8 !== 1'b1) $display("FAIL dir%0d_accept got %b want 1", v, ir8); else pass_cnt++;
      n = 0;
      for (int i = 1; i <= 8; i++) begin
        tick8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        if (ov8 === 1'b1) begin n = i; break; end
      end
      total_cnt++; if (n !== 2) $display("FAIL dir%0d_latency got %0d want 2", v, n); else pass_cnt++;
      total_cnt++; if (sum8 !== es[v]) $display("FAIL dir%0d_sum got %h want %h", v, sum8, es[v]); else pass_cnt++;
      total_cnt++; if (co8 !== ec[v]) $display("FAIL dir%0d_c_out got %b want %b", v, co8, ec[v]); else pass_cnt++;
      total_cnt++; if (of8 !== eo[v]) $display("FAIL dir%0d_overflow got %b want %b", v, of8, eo[v]); else pass_cnt++;
    end
    tick8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] ra, rb;
    logic rc, rs;
    int emitted;
    exp_t e;
    q.delete();
    emitted = 0;
    for (int t = 0; t < 30; t++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      tick8(1'b0, t < 8, ra, rb, rc, rs, 1'b1);
      if (ov8 === 1'b1) begin
        if (q.size() == 0) begin
          total_cnt++; $display("FAIL stream_extra_beat got %h want none", sum8);
        end else begin
          e = q.pop_front();
          emitted++;
          total_cnt++; if ({of8, co8, sum8} !== e.v) $display("FAIL stream_data got %h want %h", {of8, co8, sum8}, e.v); else pass_cnt++;
          total_cnt++; if (t - e.t !== 2) $display("FAIL stream_latency got %0d want 2", t - e.t); else pass_cnt++;
        end
      end
      if (t < 8) begin
        total_cnt++; if (ir8 !== 1'b1) $display("FAIL stream_in_ready got %b want 1", ir8); else pass_cnt++;
        q.push_back('{t, ref_model(8, int'(ra), int'(rb), int'(rc), int'(rs))});
      end
      if (t >= 8 && q.size() == 0) break;
    end
    total_cnt++; if (emitted !== 8) $display("FAIL stream_count got %0d want 8", emitted); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [7:0] ra, rb, held;
    logic rc, rs;
    int accepted, emitted, bad_hold;
    exp_t e;
    q.delete();
    accepted = 0;
    for (int t = 0; t < 10; t++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      tick8(1'b0, 1'b1, ra, rb, rc, rs, 1'b0);
      if (ir8 !== 1'b1) break;
      accepted++;
      q.push_back('{t, ref_model(8, int'(ra), int'(rb), int'(rc), int'(rs))});
    end
    total_cnt++; if (accepted !== 2) $display("FAIL bp_fill_count got %0d want 2", accepted); else pass_cnt++;
    total_cnt++; if (ov8 !== 1'b1) $display("FAIL bp_out_valid got %b want 1", ov8); else pass_cnt++;
    held = sum8;
    bad_hold = 0;
    for (int i = 0; i < 4; i++) begin
      tick8(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
      if (ir8 !== 1'b0 || ov8 !== 1'b1 || sum8 !== held) bad_hold++;
    end
    total_cnt++; if (bad_hold !== 0) $display("FAIL bp_hold got %0d unstable cycles want 0", bad_hold); else pass_cnt++;
    emitted = 0;
    for (int t = 0; t < 10; t++) begin
      tick8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      if (ov8 === 1'b1) begin
        emitted++;
        if (q.size() == 0) begin
          total_cnt++; $display("FAIL bp_extra_beat got %h want none", sum8);
        end else begin
          e = q.pop_front();
          total_cnt++; if ({of8, co8, sum8} !== e.v) $display("FAIL bp_drain_data got %h want %h", {of8, co8, sum8}, e.v); else pass_cnt++;
        end
      end
    end
    total_cnt++; if (emitted !== 2) $display("FAIL bp_drain_count got %0d want 2", emitted); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int stray;
    tick8(1'b0, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
    tick8(1'b0, 1'b1, 8'h56, 8'h78, 1'b1, 1'b1, 1'b0);
    tick8(1'b1, 1'b1, 8'h9A, 8'hBC, 1'b0, 1'b0, 1'b0);
    tick8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    total_cnt++; if (ov8 !== 1'b0) $display("FAIL midrst_out_valid got %b want 0", ov8); else pass_cnt++;
    total_cnt++; if (sum8 !== 8'h00) $display("FAIL midrst_sum got %h want 00", sum8); else pass_cnt++;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      tick8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      if (ov8 === 1'b1) stray++;
    end
    total_cnt++; if (stray !== 0) $display("FAIL midrst_stale got %0d beats want 0", stray); else pass_cnt++;
  endtask

  task automatic test_exhaustive_w3();
    logic [2:0] ra, rb;
    logic rc, rs;
    int emitted;
    exp_t e;
    q.delete();
    emitted = 0;
    tick3(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    for (int t = 0; t < 280; t++) begin
      ra = 3'(t); rb = 3'(t >> 3); rc = 1'(t >> 6); rs = 1'(t >> 7);
      tick3(1'b0, t < 256, ra, rb, rc, rs, 1'b1);
      if (ov3 === 1'b1) begin
        if (q.size() == 0) begin
          total_cnt++; $display("FAIL w3_extra_beat got %h want none", sum3);
        end else begin
          e = q.pop_front();
          emitted++;
          total_cnt++; if ({of3, co3, sum3} !== {e.v[9:8], e.v[2:0]}) $display("FAIL w3_data beat %0d got %h want %h", e.t, {of3, co3, sum3}, {e.v[9:8], e.v[2:0]}); else pass_cnt++;
          total_cnt++; if (t - e.t !== 3) $display("FAIL w3_latency got %0d want 3", t - e.t); else pass_cnt++;
        end
      end
      if (t < 256) begin
        total_cnt++; if (ir3 !== 1'b1) $display("FAIL w3_in_ready got %b want 1", ir3); else pass_cnt++;
        q.push_back('{t, ref_model(3, int'(ra), int'(rb), int'(rc), int'(rs))});
      end
      if (t >= 256 && q.size() == 0) break;
    end
    total_cnt++; if (emitted !== 256) $display("FAIL w3_count got %0d want 256", emitted); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_exhaustive_w3();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
